// File: rtl/fb_port_arbiter.sv
// Frame-buffer RAM port arbiter: display fetches win, buffered pixel writes drain in idle slots.
// Optional FB_ARB_VSYNC_LOCK_EN restricts write drain to vertical blanking.
module fb_port_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FIFO_AW    = 2,
  parameter int unsigned STARVE_MAX = 1023
) (
  input  logic                 clk,
  input  logic                 rest_n,
  input  logic                 disp_req,
  input  logic [ADDR_W-1:0]    disp_addr,
  output logic                 disp_valid,
  output logic [DATA_W-1:0]    disp_data,
  input  logic                 vblank,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic [DATA_W-1:0]    ram_wdata,
  input  logic [DATA_W-1:0]    ram_rdata,
  output logic [FIFO_AW:0]     fifo_level,
  output logic                 busy,
  output logic                 starve
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned LVL_W = FIFO_AW + 1;
  localparam int unsigned ENT_W = ADDR_W + DATA_W;
  localparam int unsigned CNT_W = (STARVE_MAX > 1) ? $clog2(STARVE_MAX + 1) : 1;

  typedef enum logic [1:0] {IDLE, PEND, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [ENT_W-1:0]   mem [DEPTH];
  logic [LVL_W-1:0]   wptr_q, rptr_q, wptr_d, rptr_d, level_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ENT_W-1:0]   head;
  logic               push, pop, drain_ok, starve_d, disp_d1_q;

`ifdef FB_ARB_VSYNC_LOCK_EN
  assign drain_ok = vblank & ~disp_req;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign drain_ok      = ~disp_req;
`endif

  assign disp_data = ram_rdata;

  // Grant, FIFO pointer/level update, next state and starvation counter
  always_comb begin
    push     = 1'b0;
    pop      = 1'b0;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    level_d  = fifo_level;
    head     = mem[rptr_q[FIFO_AW-1:0]];
    state_d  = state_q;
    cnt_d    = '0;
    starve_d = 1'b0;

    push    = wr_valid & wr_ready;
    pop     = (fifo_level != '0) & drain_ok;
    wptr_d  = wptr_q + LVL_W'(push);
    rptr_d  = rptr_q + LVL_W'(pop);
    level_d = fifo_level + LVL_W'(push) - LVL_W'(pop);

    if (pop)                state_d = DRAIN;
    else if (level_d != '0) state_d = PEND;
    else                    state_d = IDLE;

    case (state_q)
      PEND: begin
        if (cnt_q == CNT_W'(STARVE_MAX - 1)) starve_d = 1'b1;
        else                                 cnt_d    = cnt_q + CNT_W'(1);
      end
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rest_n) begin
    if (!rest_n) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Storage only; validity is tracked by the pointers, so no reset needed
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q[FIFO_AW-1:0]] <= {wr_addr, wr_data};
  end

  always_ff @(posedge clk or negedge rest_n) begin
    if (!rest_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      fifo_level <= '0;
      wr_ready   <= 1'b0;
      cnt_q      <= '0;
      starve     <= 1'b0;
      busy       <= 1'b0;
      disp_d1_q  <= 1'b0;
      disp_valid <= 1'b0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      fifo_level <= level_d;
      wr_ready   <= (level_d != LVL_W'(DEPTH));
      cnt_q      <= cnt_d;
      starve     <= starve_d;
      busy       <= (state_d != IDLE);
      disp_d1_q  <= disp_req;
      disp_valid <= disp_d1_q;
      if (disp_req) begin
        ram_en   <= 1'b1;
        ram_we   <= 1'b0;
        ram_addr <= disp_addr;
      end else if (pop) begin
        ram_en    <= 1'b1;
        ram_we    <= 1'b1;
        ram_addr  <= head[ENT_W-1:DATA_W];
        ram_wdata <= head[DATA_W-1:0];
      end else begin
        ram_en <= 1'b0;
        ram_we <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter: cycle model of grant/level/state plus read and write scoreboards.
module tb_fb_port_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int STARVE_LIM = 1023;

  logic clk = 1'b0;
  logic rest_n;
  logic disp_req, vblank, wr_valid;
  logic [AW-1:0] disp_addr, wr_addr, ram_addr;
  logic [DW-1:0] wr_data, ram_wdata, disp_data;
  logic [DW-1:0] ram_rdata;
  logic disp_valid, wr_ready, ram_en, ram_we, busy, starve;
  logic [2:0] fifo_level;

  fb_port_arbiter dut (
    .clk(clk), .rest_n(rest_n), .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_valid(disp_valid), .disp_data(disp_data), .vblank(vblank),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .fifo_level(fifo_level), .busy(busy), .starve(starve)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // synchronous single-port RAM model
  logic [DW-1:0] ram [65536];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else        ram_rdata     <= ram[ram_addr];
    end
  end

  function automatic logic [DW-1:0] pix(input logic [AW-1:0] a);
    return (a * 16'd7) ^ 16'hBEEF;
  endfunction

  function automatic logic may_drain(input logic req, input logic vb);
`ifdef FB_ARB_VSYNC_LOCK_EN
    return vb & ~req;
`else
    return ~req & (vb | ~vb);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [DW-1:0]      dq[$];
  logic [AW+DW-1:0]   wq[$];
  logic rq1 = 1'b0, rq2 = 1'b0;
  int   lvl = 0, cnt = 0, dv_count = 0, starve_seen = 0;
  logic rdy_m = 1'b0, starve_m = 1'b0;
  int   st_m = 0;  // 0 idle, 1 pend, 2 drain

  always @(posedge clk) begin
    if (!rest_n) begin rq1 <= 1'b0; rq2 <= 1'b0; end
    else begin rq1 <= disp_req; rq2 <= rq1; end
  end

  // Output monitor: read-data and write-order scoreboards, 2-cycle valid alignment
  always @(negedge clk) begin
    if (rest_n) begin
      if (ram_en && ram_we) begin
        if (wq.size() == 0) check("spurious_write", {ram_addr, ram_wdata}, 32'hFFFF_FFFF);
        else check("write_order", {ram_addr, ram_wdata}, wq.pop_front());
        check("write_in_disp_slot", 32'(rq1), 32'd0);
      end
      check("disp_valid_align", 32'(disp_valid), 32'(rq2));
      if (disp_valid) begin
        dv_count++;
        if (dq.size() == 0) check("spurious_disp", 32'(disp_data), 32'hFFFF_FFFF);
        else check("disp_data", 32'(disp_data), 32'(dq.pop_front()));
      end
      if (starve) starve_seen++;
    end
  end

  task automatic step(input logic req, input logic [AW-1:0] da, input logic wv,
                      input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic vb,
                      output logic acc);
    logic pop;
    int   prev_st;
    disp_req = req; disp_addr = da; wr_valid = wv; wr_addr = wa; wr_data = wd; vblank = vb;
    acc = wv & rdy_m;
    pop = (lvl != 0) & may_drain(req, vb);
    if (req) dq.push_back(pix(da));
    if (acc) wq.push_back({wa, wd});
    @(posedge clk); #1;
    prev_st = st_m;
    lvl = lvl + int'(acc) - int'(pop);
    starve_m = 1'b0;
    if (prev_st == 1) begin
      if (cnt + 1 == STARVE_LIM) begin starve_m = 1'b1; cnt = 0; end
      else cnt++;
    end else cnt = 0;
    st_m  = pop ? 2 : (lvl != 0 ? 1 : 0);
    rdy_m = (lvl != 4);
    check("ram_en", 32'(ram_en), 32'(req | pop));
    check("ram_we", 32'(ram_we), 32'(pop));
    if (req) check("ram_addr_disp", 32'(ram_addr), 32'(da));
    check("fifo_level", 32'(fifo_level), 32'(lvl));
    check("wr_ready", 32'(wr_ready), 32'(rdy_m));
    check("busy", 32'(busy), 32'(st_m != 0));
    check("starve", 32'(starve), 32'(starve_m));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ram_en"}, 32'(ram_en), 32'd0);
    check({tag, "_ram_we"}, 32'(ram_we), 32'd0);
    check({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    check({tag, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
    check({tag, "_disp_valid"}, 32'(disp_valid), 32'd0);
    check({tag, "_fifo_level"}, 32'(fifo_level), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_starve"}, 32'(starve), 32'd0);
  endtask

  task automatic model_reset();
    lvl = 0; cnt = 0; rdy_m = 1'b0; starve_m = 1'b0; st_m = 0;
    dq.delete(); wq.delete();
  endtask

  initial begin
    logic acc;
    int   idx;
    for (int i = 0; i < 65536; i++) ram[i] = pix(16'(i));
    rest_n = 1'b0; disp_req = 0; disp_addr = '0; wr_valid = 0; wr_addr = '0; wr_data = '0;
    vblank = 1'b1;
    #1;
    check_reset_outputs("por");
    @(posedge clk); @(posedge clk); #1;
    check_reset_outputs("por_held");
    rest_n = 1'b1;
    step(0, 0, 0, 0, 0, 1, acc);

    // Back-to-back display fetches 0..3
    dv_count = 0;
    for (int i = 0; i < 4; i++) step(1, 16'(i), 0, 0, 0, 1, acc);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, acc);
    check("disp_valid_count", 32'(dv_count), 32'd4);

    // Writes 10..13 with the display idle
    idx = 0;
    while (idx < 4) begin
      step(0, 0, 1, 16'(10 + idx), 16'hA0 + 16'(idx), 1, acc);
      if (acc) idx++;
    end
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 1, acc);
    check("writes_drained", 32'(wq.size()), 32'd0);
    check("ram_10", 32'(ram[10]), 32'h00A0);
    check("ram_13", 32'(ram[13]), 32'h00A3);

    // Five writes while the display holds the port; fifth stalls on full
    idx = 0;
    for (int i = 0; i < 7; i++) begin
      step(1, 16'(100 + i), (idx < 5), 16'(20 + idx), 16'hB0 + 16'(idx), 1, acc);
      if (acc) idx++;
    end
    check("stalled_at_four", 32'(idx), 32'd4);
    check("full_level", 32'(fifo_level), 32'd4);
    for (int i = 0; i < 8 && (idx < 5 || lvl != 0); i++) begin
      step(0, 0, (idx < 5), 16'(20 + idx), 16'hB0 + 16'(idx), 1, acc);
      if (acc) idx++;
    end
    check("fifth_accepted", 32'(idx), 32'd5);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, acc);
    check("ram_24", 32'(ram[24]), 32'h00B4);

    // Starvation: one pending write blocked for >1023 cycles
    step(1, 16'd200, 1, 16'd50, 16'hC0, 0, acc);
    starve_seen = 0;
    for (int i = 0; i < 1100; i++) step(1, 16'(200 + (i % 50)), 0, 0, 0, 0, acc);
    check("starve_pulses", 32'(starve_seen), 32'd1);
    step(0, 0, 0, 0, 0, 1, acc);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, acc);
    check("ram_50", 32'(ram[50]), 32'h00C0);

    // Reset mid-drain with three entries left
    idx = 0;
    for (int i = 0; i < 4; i++) begin
      step(1, 16'(300 + i), 1, 16'(30 + idx), 16'hD0 + 16'(idx), 1, acc);
      if (acc) idx++;
    end
    step(0, 0, 0, 0, 0, 1, acc);
    check("pre_reset_level", 32'(fifo_level), 32'd3);
    rest_n = 1'b0;
    #1;
    check_reset_outputs("mid_drain");
    model_reset();
    @(posedge clk); #1;
    rest_n = 1'b1;
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 1, acc);
    check("discarded_31", 32'(ram[31]), 32'(pix(16'd31)));

    // Alternating display requests with two queued writes
    for (int i = 0; i < 2; i++) step(1, 16'(400 + i), 1, 16'(40 + i), 16'hE0 + 16'(i), 1, acc);
    for (int i = 0; i < 8; i++) step(logic'(i % 2), 16'(410 + i), 0, 0, 0, 1, acc);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, acc);
    check("alt_writes_done", 32'(wq.size()), 32'd0);
    check("alt_reads_done", 32'(dq.size()), 32'd0);
    check("ram_41", 32'(ram[41]), 32'h00E1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

endmodule
